qpl_trans_sched: RTL and testbench

Per-channel session sequencer in front of qpl_transactor. It loads object keys (key_en pulse plus settle wait) and gates base/aux accesses until the translated offset is stable. It tracks in-flight accesses and quiesces all channels when the allocator wants to rewrite the switch control bits (scb). After the rewrite it re-issues every live key automatically. It sits between the processing units and the transactor and handshakes with the page allocator.

---
 rtl/qpl_sched_pkg.sv | 14 +
 rtl/qpl_sched_chan.sv | 142 ++++++++++++++
 rtl/qpl_trans_sched.sv | 126 ++++++++++++
 tb/tb_qpl_trans_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpl_sched_pkg.sv
// Shared types and helpers for the qpl_trans_sched session sequencer.
package qpl_sched_pkg;

    typedef enum logic [1:0] {IDLE, KEY, KWAIT, ACTIVE} chan_state_e;
    typedef enum logic [1:0] {RUN, QUIESCE, GRANT, REKEY} glob_state_e;

    localparam int STAT_W = 16;

    // Width of the settle counter; it must hold KEY_LAT-1.
    function automatic int key_cnt_w(input int key_lat);
        return (key_lat > 2) ? $clog2(key_lat) : 1;
    endfunction

endpackage

// File: rtl/qpl_sched_chan.sv
// One channel: session FSM, key latch, in-flight shift register and access issue register.
// QPL_SCHED_STATS_EN adds a per-channel saturating accepted-access counter.
module qpl_sched_chan
    import qpl_sched_pkg::*;
#(
    parameter int BLOCK_W = 8,
    parameter int VADDR_W = 16,
    parameter int KEY_LAT = 2,
    parameter int ACC_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_ok,
    input  logic               glob_run,
    input  logic               rekey_go,
    input  logic               open_vld,
    input  logic [BLOCK_W-1:0] open_key,
    input  logic               close,
    input  logic               acc_vld,
    input  logic               base_en,
    input  logic               aux_en,
    input  logic [VADDR_W-1:0] base_vaddr_in,
    input  logic [VADDR_W-1:0] aux_vaddr_in,
    output logic               open_rdy,
    output logic               sess_vld,
    output logic               acc_rdy,
    output logic               key_en,
    output logic [BLOCK_W-1:0] key,
    output logic               base_vld,
    output logic               aux_vld,
    output logic [VADDR_W-1:0] base_vaddr,
    output logic [VADDR_W-1:0] aux_vaddr,
    output logic               busy,
    output logic               loading
`ifdef QPL_SCHED_STATS_EN
    ,
    input  logic               stat_clr,
    output logic [STAT_W-1:0]  acc_cnt
`endif
);

    localparam int CNT_W  = key_cnt_w(KEY_LAT);
    localparam int FLT_D  = ACC_LAT + 1;

    chan_state_e        state;
    logic [CNT_W-1:0]   cnt;
    logic [BLOCK_W-1:0] key_q;
    logic               rebind;
    logic [FLT_D-1:0]   flight;
    logic               open_acc;
    logic               fire;

    // A pending rebind blocks new accesses so the in-flight register can drain.
    assign open_rdy = run_ok && ((state == IDLE) || (state == ACTIVE && !rebind));
    assign open_acc = open_vld && open_rdy && !close;
    assign acc_rdy  = run_ok && (state == ACTIVE) && !rebind && !open_vld;
    assign fire     = acc_vld && acc_rdy;

    assign key_en   = (state == KEY);
    assign key      = key_q;
    assign sess_vld = (state == ACTIVE);
    assign loading  = (state == KEY) || (state == KWAIT);
    assign busy     = loading || (|flight);

    // NOTE: all state uses non-blocking assignments so every channel and the
    // global FSM see the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            key_q  <= '0;
            rebind <= 1'b0;
        end else if (close) begin
            state  <= IDLE;
            cnt    <= '0;
            key_q  <= '0;
            rebind <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (open_acc) begin
                        key_q <= open_key;
                        state <= KEY;
                    end
                end
                KEY: begin
                    cnt   <= CNT_W'(KEY_LAT - 1);
                    state <= (KEY_LAT == 1) ? ACTIVE : KWAIT;
                end
                KWAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (open_acc) begin
                        key_q  <= open_key;
                        rebind <= 1'b1;
                    end else if (rekey_go) begin
                        state  <= KEY;
                        rebind <= 1'b0;
                    end else if (rebind && glob_run && (flight == '0)) begin
                        state  <= KEY;
                        rebind <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flight <= '0;
        else     flight <= (flight << 1) | FLT_D'(fire);
    end

    // NOTE: the address registers are reset too, so every transactor-facing
    // output reads 0 while reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_vld   <= 1'b0;
            aux_vld    <= 1'b0;
            base_vaddr <= '0;
            aux_vaddr  <= '0;
        end else begin
            base_vld <= fire && base_en;
            aux_vld  <= fire && aux_en;
            if (fire) begin
                base_vaddr <= base_vaddr_in;
                aux_vaddr  <= aux_vaddr_in;
            end
        end
    end

`ifdef QPL_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    acc_cnt <= '0;
        else if (stat_clr || open_acc)              acc_cnt <= '0;
        else if (fire && (acc_cnt != {STAT_W{1'b1}})) acc_cnt <= acc_cnt + STAT_W'(1);
    end
`endif

endmodule

// File: rtl/qpl_trans_sched.sv
// Per-channel session sequencer in front of qpl_transactor with scb-rewrite quiesce/rekey.
// Optional QPL_SCHED_STATS_EN adds o_acc_cnt and i_stat_clr.
module qpl_trans_sched
    import qpl_sched_pkg::*;
#(
    parameter  int CHANS   = 8,
    parameter  int BLOCK_D = 256,
    parameter  int WORD_W  = 8,
    parameter  int KEY_LAT = 2,
    parameter  int ACC_LAT = 1,
    localparam int BLOCK_W = $clog2(BLOCK_D),
    localparam int VADDR_W = BLOCK_W + WORD_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [CHANS-1:0]           i_open_vld,
    input  logic [CHANS*BLOCK_W-1:0]   i_open_key,
    output logic [CHANS-1:0]           o_open_rdy,
    input  logic [CHANS-1:0]           i_close,
    output logic [CHANS-1:0]           o_sess_vld,
    input  logic [CHANS-1:0]           i_acc_vld,
    input  logic [CHANS-1:0]           i_acc_base_en,
    input  logic [CHANS-1:0]           i_acc_aux_en,
    input  logic [CHANS*VADDR_W-1:0]   i_acc_base_vaddr,
    input  logic [CHANS*VADDR_W-1:0]   i_acc_aux_vaddr,
    output logic [CHANS-1:0]           o_acc_rdy,
    output logic [CHANS-1:0]           o_key_en,
    output logic [CHANS*BLOCK_W-1:0]   o_key,
    output logic [CHANS-1:0]           o_base_vld,
    output logic [CHANS-1:0]           o_aux_vld,
    output logic [CHANS*VADDR_W-1:0]   o_base_vaddr,
    output logic [CHANS*VADDR_W-1:0]   o_aux_vaddr,
    input  logic                       i_scb_upd_req,
    output logic                       o_scb_upd_gnt,
    input  logic                       i_scb_upd_done
`ifdef QPL_SCHED_STATS_EN
    ,
    output logic [CHANS*STAT_W-1:0]    o_acc_cnt,
    input  logic                       i_stat_clr
`endif
);

    glob_state_e      gstate;
    logic [CHANS-1:0] busy;
    logic [CHANS-1:0] loading;
    logic             run_ok;
    logic             glob_run;
    logic             rekey_go;

    // New work is refused in the same cycle the allocator raises its request.
    assign glob_run = (gstate == RUN);
    assign run_ok   = glob_run && !i_scb_upd_req;
    assign rekey_go = (gstate == GRANT) && i_scb_upd_done;

    for (genvar c = 0; c < CHANS; c++) begin : g_chan
        qpl_sched_chan #(
            .BLOCK_W (BLOCK_W),
            .VADDR_W (VADDR_W),
            .KEY_LAT (KEY_LAT),
            .ACC_LAT (ACC_LAT)
        ) u_chan (
            .clk           (i_clk),
            .rst           (i_rst),
            .run_ok        (run_ok),
            .glob_run      (glob_run),
            .rekey_go      (rekey_go),
            .open_vld      (i_open_vld[c]),
            .open_key      (i_open_key[c*BLOCK_W +: BLOCK_W]),
            .close         (i_close[c]),
            .acc_vld       (i_acc_vld[c]),
            .base_en       (i_acc_base_en[c]),
            .aux_en        (i_acc_aux_en[c]),
            .base_vaddr_in (i_acc_base_vaddr[c*VADDR_W +: VADDR_W]),
            .aux_vaddr_in  (i_acc_aux_vaddr[c*VADDR_W +: VADDR_W]),
            .open_rdy      (o_open_rdy[c]),
            .sess_vld      (o_sess_vld[c]),
            .acc_rdy       (o_acc_rdy[c]),
            .key_en        (o_key_en[c]),
            .key           (o_key[c*BLOCK_W +: BLOCK_W]),
            .base_vld      (o_base_vld[c]),
            .aux_vld       (o_aux_vld[c]),
            .base_vaddr    (o_base_vaddr[c*VADDR_W +: VADDR_W]),
            .aux_vaddr     (o_aux_vaddr[c*VADDR_W +: VADDR_W]),
            .busy          (busy[c]),
            .loading       (loading[c])
`ifdef QPL_SCHED_STATS_EN
            ,
            .stat_clr      (i_stat_clr),
            .acc_cnt       (o_acc_cnt[c*STAT_W +: STAT_W])
`endif
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gstate        <= RUN;
            o_scb_upd_gnt <= 1'b0;
        end else begin
            case (gstate)
                RUN: begin
                    if (i_scb_upd_req) gstate <= QUIESCE;
                end
                QUIESCE: begin
                    if (!i_scb_upd_req) begin
                        gstate <= RUN;
                    end else if (busy == '0) begin
                        gstate        <= GRANT;
                        o_scb_upd_gnt <= 1'b1;
                    end
                end
                GRANT: begin
                    if (i_scb_upd_done) begin
                        gstate        <= REKEY;
                        o_scb_upd_gnt <= 1'b0;
                    end
                end
                REKEY: begin
                    // Channels re-entered KEY on the GRANT exit edge; wait for all loads.
                    if (loading == '0) gstate <= RUN;
                end
                default: gstate <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_qpl_trans_sched.sv
// Scoreboard bench for qpl_trans_sched; define QPL_SCHED_STATS_EN to exercise the access counters.
module tb_qpl_trans_sched;

    localparam int CHANS   = 8;
    localparam int BLOCK_W = 8;
    localparam int VADDR_W = 16;

    typedef struct packed {
        logic [2:0]  ch;
        logic        bv;
        logic        av;
        logic [15:0] ba;
        logic [15:0] aa;
    } acc_t;

    logic                     i_clk = 1'b0;
    logic                     i_rst;
    logic [CHANS-1:0]         i_open_vld;
    logic [CHANS*BLOCK_W-1:0] i_open_key;
    logic [CHANS-1:0]         o_open_rdy;
    logic [CHANS-1:0]         i_close;
    logic [CHANS-1:0]         o_sess_vld;
    logic [CHANS-1:0]         i_acc_vld;
    logic [CHANS-1:0]         i_acc_base_en;
    logic [CHANS-1:0]         i_acc_aux_en;
    logic [CHANS*VADDR_W-1:0] i_acc_base_vaddr;
    logic [CHANS*VADDR_W-1:0] i_acc_aux_vaddr;
    logic [CHANS-1:0]         o_acc_rdy;
    logic [CHANS-1:0]         o_key_en;
    logic [CHANS*BLOCK_W-1:0] o_key;
    logic [CHANS-1:0]         o_base_vld;
    logic [CHANS-1:0]         o_aux_vld;
    logic [CHANS*VADDR_W-1:0] o_base_vaddr;
    logic [CHANS*VADDR_W-1:0] o_aux_vaddr;
    logic                     i_scb_upd_req;
    logic                     o_scb_upd_gnt;
    logic                     i_scb_upd_done;
`ifdef QPL_SCHED_STATS_EN
    logic [CHANS*16-1:0]      o_acc_cnt;
    logic                     i_stat_clr;
`endif

    int   checks = 0;
    int   errors = 0;
    acc_t sb_q[$];

    always #5 i_clk = ~i_clk;

    qpl_trans_sched dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_open_vld       (i_open_vld),
        .i_open_key       (i_open_key),
        .o_open_rdy       (o_open_rdy),
        .i_close          (i_close),
        .o_sess_vld       (o_sess_vld),
        .i_acc_vld        (i_acc_vld),
        .i_acc_base_en    (i_acc_base_en),
        .i_acc_aux_en     (i_acc_aux_en),
        .i_acc_base_vaddr (i_acc_base_vaddr),
        .i_acc_aux_vaddr  (i_acc_aux_vaddr),
        .o_acc_rdy        (o_acc_rdy),
        .o_key_en         (o_key_en),
        .o_key            (o_key),
        .o_base_vld       (o_base_vld),
        .o_aux_vld        (o_aux_vld),
        .o_base_vaddr     (o_base_vaddr),
        .o_aux_vaddr      (o_aux_vaddr),
        .i_scb_upd_req    (i_scb_upd_req),
        .o_scb_upd_gnt    (o_scb_upd_gnt),
        .i_scb_upd_done   (i_scb_upd_done)
`ifdef QPL_SCHED_STATS_EN
        ,
        .o_acc_cnt        (o_acc_cnt),
        .i_stat_clr       (i_stat_clr)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_acc(input int ch, input logic be, input logic ae,
                           input logic [15:0] bva, input logic [15:0] ava);
        acc_t e;
        i_acc_vld[ch]                        = 1'b1;
        i_acc_base_en[ch]                    = be;
        i_acc_aux_en[ch]                     = ae;
        i_acc_base_vaddr[ch*VADDR_W +: VADDR_W] = bva;
        i_acc_aux_vaddr[ch*VADDR_W +: VADDR_W]  = ava;
        e.ch = 3'(ch);
        e.bv = be;
        e.av = ae;
        e.ba = be ? bva : 16'h0;
        e.aa = ae ? ava : 16'h0;
        sb_q.push_back(e);
    endtask

    task automatic clear_acc(input int ch);
        i_acc_vld[ch]     = 1'b0;
        i_acc_base_en[ch] = 1'b0;
        i_acc_aux_en[ch]  = 1'b0;
    endtask

    task automatic open_chan(input int ch, input logic [7:0] k);
        i_open_vld[ch]                     = 1'b1;
        i_open_key[ch*BLOCK_W +: BLOCK_W]  = k;
        tick();
        i_open_vld[ch] = 1'b0;
        @(negedge i_clk);
        check("open_key_en", o_key_en, 64'(1) << ch);
        check("open_key", o_key[ch*BLOCK_W +: BLOCK_W], k);
        for (int n = 0; n < 8 && !o_sess_vld[ch]; n++) @(negedge i_clk);
        check("open_sess", o_sess_vld[ch], 1);
    endtask

    // Transactor-side monitor: every issued access must match the oldest expected one.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            for (int c = 0; c < CHANS; c++) begin
                if (o_base_vld[c] || o_aux_vld[c]) begin
                    acc_t obs;
                    obs.ch = 3'(c);
                    obs.bv = o_base_vld[c];
                    obs.av = o_aux_vld[c];
                    obs.ba = o_base_vld[c] ? o_base_vaddr[c*VADDR_W +: VADDR_W] : 16'h0;
                    obs.aa = o_aux_vld[c] ? o_aux_vaddr[c*VADDR_W +: VADDR_W] : 16'h0;
                    if (sb_q.size() == 0) check("acc_unexpected", obs, 0);
                    else                  check("acc_out", obs, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] b_va [3];
        logic [15:0] a_va [3];
        logic        b_en [3];
        logic        a_en [3];
        logic        seen;

        b_va = '{16'h0105, 16'h0106, 16'h0000};
        a_va = '{16'h0000, 16'h0000, 16'h0207};
        b_en = '{1'b1, 1'b1, 1'b0};
        a_en = '{1'b0, 1'b0, 1'b1};

        i_rst            = 1'b1;
        i_open_vld       = '0;
        i_open_key       = '0;
        i_close          = '0;
        i_acc_vld        = '0;
        i_acc_base_en    = '0;
        i_acc_aux_en     = '0;
        i_acc_base_vaddr = '0;
        i_acc_aux_vaddr  = '0;
        i_scb_upd_req    = 1'b0;
        i_scb_upd_done   = 1'b0;
`ifdef QPL_SCHED_STATS_EN
        i_stat_clr       = 1'b0;
`endif

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_open_rdy", o_open_rdy, 8'hFF);
        check("rst_sess", o_sess_vld, 0);
        check("rst_acc_rdy", o_acc_rdy, 0);
        check("rst_key_en", o_key_en, 0);
        check("rst_key", o_key, 0);
        check("rst_vld", o_base_vld | o_aux_vld, 0);
        check("rst_gnt", o_scb_upd_gnt, 0);
        i_rst = 1'b0;

        // Open ch0 with key 0x3A: key_en one cycle, session valid two cycles later
        tick();
        i_open_vld[0]  = 1'b1;
        i_open_key[7:0] = 8'h3A;
        @(negedge i_clk);
        check("open0_rdy", o_open_rdy[0], 1);
        check("open0_pre_key_en", o_key_en, 0);
        tick();
        i_open_vld[0] = 1'b0;
        @(negedge i_clk);
        check("open0_key_en", o_key_en, 8'h01);
        check("open0_key", o_key[7:0], 8'h3A);
        check("open0_rdy_key", o_acc_rdy[0], 0);
        check("open0_sess_key", o_sess_vld[0], 0);
        tick();
        @(negedge i_clk);
        check("open0_key_en_off", o_key_en, 0);
        check("open0_sess_wait", o_sess_vld[0], 0);
        check("open0_rdy_wait", o_acc_rdy[0], 0);
        tick();
        @(negedge i_clk);
        check("open0_sess", o_sess_vld[0], 1);
        check("open0_acc_rdy", o_acc_rdy[0], 1);

        // Back-to-back accesses on ch0, one issue per cycle
        for (int i = 0; i < 3; i++) begin
            set_acc(0, b_en[i], a_en[i], b_va[i], a_va[i]);
            tick();
            @(negedge i_clk);
            check("burst_vld", o_base_vld[0] | o_aux_vld[0], 1);
            check("burst_rdy", o_acc_rdy[0], 1);
        end
        clear_acc(0);
        tick();
        @(negedge i_clk);
        check("burst_end", o_base_vld | o_aux_vld, 0);

        open_chan(1, 8'h55);
        open_chan(2, 8'h7C);

        // Done pulse outside GRANT is ignored
        i_scb_upd_done = 1'b1;
        tick();
        i_scb_upd_done = 1'b0;
        @(negedge i_clk);
        check("stray_done_key_en", o_key_en, 0);
        check("stray_done_gnt", o_scb_upd_gnt, 0);
        check("stray_done_rdy", o_acc_rdy[0], 1);

        // Request dropped during QUIESCE returns to RUN without a grant
        set_acc(0, 1'b1, 1'b0, 16'h0AAA, 16'h0);
        tick();
        clear_acc(0);
        i_scb_upd_req = 1'b1;
        #1;
        check("abort_rdy_drop", o_acc_rdy, 0);
        tick();
        i_scb_upd_req = 1'b0;
        @(negedge i_clk);
        check("abort_gnt_q", o_scb_upd_gnt, 0);
        check("abort_rdy_q", o_acc_rdy[0], 0);
        tick();
        @(negedge i_clk);
        check("abort_gnt_run", o_scb_upd_gnt, 0);
        check("abort_rdy_run", o_acc_rdy[0], 1);

        // ch1 access then scb request: grant only after ch1 drains
        set_acc(1, 1'b1, 1'b1, 16'h1234, 16'h4321);
        tick();
        clear_acc(1);
        i_scb_upd_req = 1'b1;
        i_acc_vld[2]                = 1'b1;
        i_acc_base_en[2]            = 1'b1;
        i_acc_base_vaddr[47:32]     = 16'hDEAD;
        #1;
        check("quiesce_acc_rdy", o_acc_rdy, 0);
        check("quiesce_open_rdy", o_open_rdy, 0);
        @(negedge i_clk);
        check("quiesce_gnt0", o_scb_upd_gnt, 0);
        tick();
        @(negedge i_clk);
        check("quiesce_gnt1", o_scb_upd_gnt, 0);
        for (int n = 0; n < 6 && !o_scb_upd_gnt; n++) begin
            tick();
            @(negedge i_clk);
        end
        check("gnt_rise", o_scb_upd_gnt, 1);
        check("gnt_sess", o_sess_vld, 8'h07);
        clear_acc(2);
        tick();
        @(negedge i_clk);
        check("gnt_hold", o_scb_upd_gnt, 1);

        // Close ch1 while granted, then finish the rewrite: ch0 and ch2 rekey together
        i_close[1] = 1'b1;
        tick();
        i_close[1] = 1'b0;
        @(negedge i_clk);
        check("close1_sess", o_sess_vld[1], 0);
        check("close1_gnt", o_scb_upd_gnt, 1);
        i_scb_upd_done = 1'b1;
        i_scb_upd_req  = 1'b0;
        tick();
        i_scb_upd_done = 1'b0;
        @(negedge i_clk);
        check("rekey_key_en", o_key_en, 8'h05);
        check("rekey_key0", o_key[7:0], 8'h3A);
        check("rekey_key2", o_key[23:16], 8'h7C);
        check("rekey_gnt_off", o_scb_upd_gnt, 0);
        check("rekey_rdy", o_acc_rdy, 0);
        tick();
        @(negedge i_clk);
        check("rekey_key_en_off", o_key_en, 0);
        check("rekey_rdy_wait", o_acc_rdy, 0);
        for (int n = 0; n < 6 && !o_acc_rdy[0]; n++) begin
            tick();
            @(negedge i_clk);
        end
        check("rekey_run_rdy", o_acc_rdy, 8'h05);
        set_acc(2, 1'b1, 1'b0, 16'h2222, 16'h0);
        tick();
        clear_acc(2);
        @(negedge i_clk);

        // Close and open on ch3 in the same cycle: close wins
        i_close[3]       = 1'b1;
        i_open_vld[3]    = 1'b1;
        i_open_key[31:24] = 8'h11;
        tick();
        i_close[3]    = 1'b0;
        i_open_vld[3] = 1'b0;
        @(negedge i_clk);
        seen = o_key_en[3];
        tick();
        @(negedge i_clk);
        seen = seen | o_key_en[3];
        check("co3_no_key_en", seen, 0);
        check("co3_sess", o_sess_vld[3], 0);
        check("co3_open_rdy", o_open_rdy[3], 1);

        // Reset asserted while ch4 is in KWAIT
        i_open_vld[4]     = 1'b1;
        i_open_key[39:32] = 8'h22;
        tick();
        i_open_vld[4] = 1'b0;
        tick();
        #2;
        i_rst = 1'b1;
        #1;
        check("arst_key_en", o_key_en, 0);
        check("arst_key", o_key, 0);
        check("arst_sess", o_sess_vld, 0);
        check("arst_acc_rdy", o_acc_rdy, 0);
        check("arst_open_rdy", o_open_rdy, 8'hFF);
        check("arst_gnt", o_scb_upd_gnt, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge i_clk);
            seen = seen | (|o_key_en) | (|o_sess_vld);
        end
        check("arst_no_rekey", seen, 0);

`ifdef QPL_SCHED_STATS_EN
        open_chan(0, 8'h01);
        i_acc_vld[0] = 1'b1;
        repeat (5) tick();
        i_acc_vld[0] = 1'b0;
        @(negedge i_clk);
        check("stat_cnt5", o_acc_cnt[15:0], 16'd5);
        i_acc_vld[0] = 1'b1;
        repeat (70000) tick();
        i_acc_vld[0] = 1'b0;
        @(negedge i_clk);
        check("stat_sat", o_acc_cnt[15:0], 16'hFFFF);
        i_stat_clr = 1'b1;
        tick();
        i_stat_clr = 1'b0;
        @(negedge i_clk);
        check("stat_clr", o_acc_cnt[15:0], 16'h0);
`endif

        repeat (3) @(negedge i_clk);
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
